// File: rtl/systolic_array_stream_ctrl.sv
// systolic_array_stream_ctrl: packs an X/Y element stream into the array buses,
// runs one systolic job and streams the captured Z elements back out.
`default_nettype none

module systolic_array_stream_ctrl #(
   parameter int BITWIDTH                 = 8,
   parameter int IS_BITWIDTH_DOUBLE_SCALE = 0,
   parameter int X_ROW                    = 3,
   parameter int XCOL_YROW                = 3,
   parameter int Y_COL                    = 3
) (
   input  logic                                                          sys_clk,
   input  logic                                                          sys_rst,
   input  logic                                                          s_valid,
   output logic                                                          s_ready,
   input  logic [BITWIDTH-1:0]                                           s_data,
   output logic                                                          m_valid,
   input  logic                                                          m_ready,
   output logic [BITWIDTH*(IS_BITWIDTH_DOUBLE_SCALE+1)-1:0]              m_data,
   output logic                                                          m_last,
   output logic                                                          sa_start,
   input  logic                                                          sa_done,
   output logic [BITWIDTH*X_ROW*XCOL_YROW-1:0]                           sa_X,
   output logic [BITWIDTH*XCOL_YROW*Y_COL-1:0]                           sa_Y,
   input  logic [BITWIDTH*(IS_BITWIDTH_DOUBLE_SCALE+1)*X_ROW*Y_COL-1:0]  sa_Z,
   output logic                                                          busy,
   output logic [15:0]                                                   run_cycles
);

   localparam int ZW   = BITWIDTH * (IS_BITWIDTH_DOUBLE_SCALE + 1);
   localparam int NX   = X_ROW * XCOL_YROW;
   localparam int NY   = XCOL_YROW * Y_COL;
   localparam int NZ   = X_ROW * Y_COL;
   localparam int XW   = BITWIDTH * NX;
   localparam int YW   = BITWIDTH * NY;
   localparam int ZTW  = ZW * NZ;
   localparam int NXY  = (NX > NY) ? NX : NY;
   localparam int NMAX = (NXY > NZ) ? NXY : NZ;
   localparam int IDXW = (NMAX > 1) ? $clog2(NMAX) : 1;

   localparam logic [IDXW-1:0] X_LAST = IDXW'(NX - 1);
   localparam logic [IDXW-1:0] Y_LAST = IDXW'(NY - 1);
   localparam logic [IDXW-1:0] Z_LAST = IDXW'(NZ - 1);
   localparam logic [XW-1:0]   X_MASK = XW'({BITWIDTH{1'b1}});
   localparam logic [YW-1:0]   Y_MASK = YW'({BITWIDTH{1'b1}});

   typedef enum logic [1:0] {
      LOAD_X = 2'd0,
      LOAD_Y = 2'd1,
      RUN    = 2'd2,
      DRAIN  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic [XW-1:0]     x_q, x_d;
   logic [YW-1:0]     y_q, y_d;
   logic [ZTW-1:0]    z_q, z_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [15:0]       run_q, run_d;
   logic              sready_q, sready_d;
   logic              mvalid_q, mvalid_d;

   logic              s_fire;
   logic              m_fire;
   logic [15:0]       cnt_inc;
   int                xsh;
   int                ysh;
   int                zsh;

   // Element k sits at bit offset W*(N-1-k): element (0,0) lives in the MSBs.
   assign xsh     = BITWIDTH * (NX - 1 - int'(idx_q));
   assign ysh     = BITWIDTH * (NY - 1 - int'(idx_q));
   assign zsh     = ZW * (NZ - 1 - int'(idx_q));
   assign s_fire  = s_valid && sready_q;
   assign m_fire  = mvalid_q && m_ready;
   assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q  <= LOAD_X;
         idx_q    <= '0;
         x_q      <= '0;
         y_q      <= '0;
         z_q      <= '0;
         cnt_q    <= '0;
         run_q    <= '0;
         sready_q <= 1'b0;
         mvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         x_q      <= x_d;
         y_q      <= y_d;
         z_q      <= z_d;
         cnt_q    <= cnt_d;
         run_q    <= run_d;
         sready_q <= sready_d;
         mvalid_q <= mvalid_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      x_d      = x_q;
      y_d      = y_q;
      z_d      = z_q;
      cnt_d    = cnt_q;
      run_d    = run_q;
      mvalid_d = mvalid_q;
      case (state_q)
         LOAD_X: begin
            if (s_fire) begin
               x_d = (x_q & ~(X_MASK << xsh)) | (XW'(s_data) << xsh);
               if (idx_q == X_LAST) begin
                  idx_d   = '0;
                  state_d = LOAD_Y;
               end else begin
                  idx_d = idx_q + IDXW'(1);
               end
            end
         end
         LOAD_Y: begin
            if (s_fire) begin
               y_d = (y_q & ~(Y_MASK << ysh)) | (YW'(s_data) << ysh);
               if (idx_q == Y_LAST) begin
                  idx_d   = '0;
                  cnt_d   = '0;
                  state_d = RUN;
               end else begin
                  idx_d = idx_q + IDXW'(1);
               end
            end
         end
         RUN: begin
            cnt_d = cnt_inc;
            // Count includes the cycle done is sampled, since start is still high then.
            if (sa_done) begin
               z_d      = sa_Z;
               run_d    = cnt_inc;
               cnt_d    = '0;
               mvalid_d = 1'b1;
               state_d  = DRAIN;
            end
         end
         DRAIN: begin
            if (m_fire) begin
               if (idx_q == Z_LAST) begin
                  idx_d    = '0;
                  mvalid_d = 1'b0;
                  state_d  = LOAD_X;
               end else begin
                  idx_d = idx_q + IDXW'(1);
               end
            end
         end
         default: state_d = LOAD_X;
      endcase
   end

   // Registered ready keeps s_ready low for the first cycle out of reset.
   assign sready_d   = (state_d == LOAD_X) || (state_d == LOAD_Y);

   assign s_ready    = sready_q;
   assign m_valid    = mvalid_q;
   assign m_data     = ZW'(z_q >> zsh);
   assign m_last     = mvalid_q && (idx_q == Z_LAST);
   assign sa_start   = (state_q == RUN);
   assign sa_X       = x_q;
   assign sa_Y       = y_q;
   assign busy       = !((state_q == LOAD_X) && (idx_q == '0));
   assign run_cycles = run_q;

endmodule

`default_nettype wire
